// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU buffer-load path.
// Holds FSM encoding, load modes and burst sizing.
package tpu_pkg;

  localparam int BURST_BEATS = 16;

  localparam logic MODE_WEIGHT = 1'b0;
  localparam logic MODE_KERNEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } load_state_t;

  function automatic logic [31:0] burst_count(
    input logic [31:0] len,
    input int          beats_log
  );
    logic [31:0] round;
    round = (32'd1 << beats_log) - 32'd1;
    return (len + round) >> beats_log;
  endfunction

endpackage

// File: rtl/cu_sel_counter.sv
// Round-robin conv-unit / kernel-slot selector.
// Kernel mode steps k first, then carries into cu.
module cu_sel_counter
  import tpu_pkg::*;
#(
  parameter int N_CONV_UNIT = 64,
  parameter int N_KERNEL    = 3,
  parameter int CW = $clog2(N_CONV_UNIT),
  parameter int KW = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          clear,
  input  logic          en,
  input  logic          mode,
  output logic [CW-1:0] cu_sel,
  output logic [KW-1:0] k_sel
);

  localparam logic [CW-1:0] CU_LAST = CW'(N_CONV_UNIT - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(N_KERNEL - 1);

  logic [CW-1:0] cu_inc;

  assign cu_inc = (cu_sel == CU_LAST) ? '0 : cu_sel + 1'b1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cu_sel <= '0;
      k_sel  <= '0;
    end else if (clear) begin
      cu_sel <= '0;
      k_sel  <= '0;
    end else if (en) begin
      if (mode == MODE_KERNEL) begin
        if (k_sel == K_LAST) begin
          k_sel  <= '0;
          cu_sel <= cu_inc;
        end else begin
          k_sel <= k_sel + 1'b1;
        end
      end else begin
        cu_sel <= cu_inc;
      end
    end
  end

endmodule

// File: rtl/cu_buffer_loader.sv
// Burst-reads DDR and scatters beats round-robin
// into conv-unit weight buffers or kernel slots.
module cu_buffer_loader #(
  parameter int DATA_WIDTH  = 64,
  parameter int N_CONV_UNIT = 64,
  parameter int N_KERNEL    = 3,
  parameter int BURST_BEATS = tpu_pkg::BURST_BEATS,
  parameter int B_LEN       = 24
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          load_start,
  input  logic                          load_mode,
  input  logic [31:0]                   load_addr,
  input  logic [B_LEN-1:0]              load_len,
  output logic                          load_busy,
  output logic                          load_done,
  output logic                          rstart,
  output logic [31:0]                   raddr,
  output logic [31:0]                   rnburst,
  input  logic                          ridle,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         buf_di,
  output logic [N_CONV_UNIT-1:0]        wb_we,
  output logic [N_CONV_UNIT*N_KERNEL-1:0] kb_we
);

  import tpu_pkg::*;

  localparam int BURST_LOG = $clog2(BURST_BEATS);
  localparam int NB_W = B_LEN - BURST_LOG;
  localparam int CW   = $clog2(N_CONV_UNIT);
  localparam int KW   = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1;
  localparam int NKB  = N_CONV_UNIT * N_KERNEL;
  localparam int KBW  = $clog2(NKB);

  localparam logic [N_CONV_UNIT-1:0] WB_ONE = N_CONV_UNIT'(1);
  localparam logic [NKB-1:0]         KB_ONE = NKB'(1);

  load_state_t state;
  load_state_t state_nxt;

  logic             mode_r;
  logic [B_LEN-1:0] len_r;
  logic [B_LEN-1:0] beat_cnt;
  logic [B_LEN-1:0] beat_inc;
  logic [B_LEN-1:0] total;
  logic [NB_W-1:0]  nb_r;
  logic             issued;
  logic             accept;
  logic             start_ok;
  logic             wr_en;
  logic [CW-1:0]    cu_sel;
  logic [KW-1:0]    k_sel;
  logic [KBW-1:0]   kb_idx;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign start_ok = (state == ST_IDLE) & load_start;
  assign wr_en    = accept & (state == ST_STREAM);
  assign beat_inc = beat_cnt + B_LEN'(1);
  assign total    = {nb_r, {BURST_LOG{1'b0}}};
  assign rnburst  = 32'(nb_r);
  assign kb_idx   = KBW'(cu_sel) * KBW'(N_KERNEL)
                  + KBW'(k_sel);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt = (load_len != '0) ? ST_REQ
                                       : ST_DONE;
        end
      end
      // Wait for axi_mst to go idle, take the start, then go busy
      ST_REQ: begin
        if (issued && !ridle) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept && beat_inc == len_r) begin
          state_nxt = (total > len_r) ? ST_DRAIN
                                      : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (accept && beat_inc == total) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_busy     = (state != ST_IDLE);
    load_done     = (state == ST_DONE);
    rstart        = (state == ST_REQ);
    s_axis_tready = (state == ST_STREAM)
                  | (state == ST_DRAIN);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mode_r   <= MODE_WEIGHT;
      len_r    <= '0;
      nb_r     <= '0;
      raddr    <= '0;
      beat_cnt <= '0;
      issued   <= 1'b0;
    end else begin
      if (start_ok) begin
        mode_r   <= load_mode;
        len_r    <= load_len;
        raddr    <= load_addr;
        nb_r     <= NB_W'(burst_count(32'(load_len),
                                      BURST_LOG));
        beat_cnt <= '0;
        issued   <= 1'b0;
      end else if (accept) begin
        beat_cnt <= beat_inc;
      end
      if (state == ST_REQ && ridle) issued <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      buf_di <= '0;
      wb_we  <= '0;
      kb_we  <= '0;
    end else begin
      wb_we <= '0;
      kb_we <= '0;
      if (wr_en) begin
        buf_di <= s_axis_tdata;
        if (mode_r == MODE_KERNEL) begin
          kb_we <= KB_ONE << kb_idx;
        end else begin
          wb_we <= WB_ONE << cu_sel;
        end
      end
    end
  end

  cu_sel_counter #(
    .N_CONV_UNIT (N_CONV_UNIT),
    .N_KERNEL    (N_KERNEL)
  ) u_sel (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (start_ok),
    .en      (wr_en),
    .mode    (mode_r),
    .cu_sel  (cu_sel),
    .k_sel   (k_sel)
  );

endmodule

// File: tb/tb_cu_buffer_loader.sv
// Directed + randomized bench for cu_buffer_loader
// with a behavioural axi_mst model and scatter reference.
module tb_cu_buffer_loader;

  localparam int DW  = 64;
  localparam int NCU = 64;
  localparam int NK  = 3;
  localparam int BL  = 24;
  localparam int BB  = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          load_start = 1'b0;
  logic          load_mode = 1'b0;
  logic [31:0]   load_addr = '0;
  logic [BL-1:0] load_len = '0;
  logic          load_busy;
  logic          load_done;
  logic          rstart;
  logic [31:0]   raddr;
  logic [31:0]   rnburst;
  logic          ridle;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] buf_di;
  logic [NCU-1:0]    wb_we;
  logic [NCU*NK-1:0] kb_we;

  logic m_idle = 1'b1;
  logic hold_busy = 1'b0;
  bit   gaps = 1'b0;

  assign ridle = m_idle & ~hold_busy;

  always #5 aclk = ~aclk;

  cu_buffer_loader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load_start    (load_start),
    .load_mode     (load_mode),
    .load_addr     (load_addr),
    .load_len      (load_len),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .rstart        (rstart),
    .raddr         (raddr),
    .rnburst       (rnburst),
    .ridle         (ridle),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .buf_di        (buf_di),
    .wb_we         (wb_we),
    .kb_we         (kb_we)
  );

  typedef struct {
    bit          kb;
    int          idx;
    int          bits;
    logic [63:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [63:0] sent[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_n = 0;
  int done_cyc = -1;
  int start_cyc = -1;
  int last_fire_cyc = -1;
  int rstart_n = 0;
  logic [31:0] seen_addr = '0;
  logic [31:0] seen_nb = '0;

  // axi_mst model: takes rstart when idle, then streams nb*16 beats
  initial begin : axi_model
    bit fire, start, rst;
    int remaining;
    logic [31:0] nb;
    remaining = 0;
    forever begin
      @(negedge aclk);
      fire  = s_axis_tvalid && s_axis_tready;
      start = rstart && ridle;
      rst   = !aresetn;
      nb    = rnburst;
      @(posedge aclk);
      #1;
      if (rst) begin
        m_idle = 1'b1;
        s_axis_tvalid = 1'b0;
        remaining = 0;
      end else begin
        if (fire) begin
          sent.push_back(s_axis_tdata);
          remaining--;
          s_axis_tvalid = 1'b0;
          if (remaining == 0) m_idle = 1'b1;
        end
        if (start) begin
          remaining = int'(nb) * BB;
          m_idle = 1'b0;
        end
        if (remaining != 0 && !s_axis_tvalid &&
            (!gaps || $urandom_range(0, 2) != 0)) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = {$urandom, $urandom};
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge aclk);
      cyc++;
      if (aresetn) begin
        if (load_start && !load_busy) start_cyc = cyc;
        if (s_axis_tvalid && s_axis_tready)
          last_fire_cyc = cyc;
        if (load_done) begin
          done_n++;
          done_cyc = cyc;
        end
        if (rstart) begin
          rstart_n++;
          seen_addr = raddr;
          seen_nb   = rnburst;
        end
        if (wb_we != '0 || kb_we != '0) begin
          wr_t w;
          w.bits = 0;
          w.kb = 1'b0;
          w.idx = -1;
          for (int i = 0; i < NCU; i++) begin
            if (wb_we[i]) begin
              w.bits++;
              w.idx = i;
            end
          end
          for (int i = 0; i < NCU * NK; i++) begin
            if (kb_we[i]) begin
              w.bits++;
              w.idx = i;
              w.kb = 1'b1;
            end
          end
          w.d = buf_di;
          wq.push_back(w);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_load(input bit mode,
                          input logic [31:0] addr,
                          input int len,
                          input bit dup,
                          input bit hold);
    int t;
    int bad;
    int nb_exp;
    int idx_exp;
    wq.delete();
    sent.delete();
    done_n = 0;
    rstart_n = 0;
    done_cyc = -1;
    seen_nb = '0;
    seen_addr = '0;
    nb_exp = (len + BB - 1) / BB;
    @(posedge aclk);
    #1;
    hold_busy  = hold;
    load_start = 1'b1;
    load_mode  = mode;
    load_addr  = addr;
    load_len   = BL'(len);
    @(posedge aclk);
    #1;
    load_start = 1'b0;
    load_mode  = ~mode;
    load_addr  = $urandom;
    load_len   = BL'($urandom);
    if (hold) begin
      repeat (4) @(negedge aclk);
      chk("req_hold", {rstart, s_axis_tready, load_busy},
          3'b101);
      @(posedge aclk);
      #1;
      hold_busy = 1'b0;
    end
    if (dup) begin
      repeat (6) @(posedge aclk);
      #1;
      load_start = 1'b1;
      load_mode  = ~mode;
      load_len   = BL'(5);
      @(posedge aclk);
      #1;
      load_start = 1'b0;
    end
    t = 0;
    while (done_n == 0 && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    chk("done_timeout", 64'(t < 3000), 64'd1);
    repeat (3) @(negedge aclk);
    chk("done_count", done_n, 1);
    chk("idle_busy", load_busy, 1'b0);
    if (len == 0) begin
      chk("done_len0", done_cyc, start_cyc + 1);
      chk("no_rstart", rstart_n, 0);
    end else begin
      chk("done_timing", done_cyc, last_fire_cyc + 1);
      chk("rnburst", seen_nb, nb_exp);
      chk("raddr", seen_addr, addr);
      chk("beats_taken", sent.size(), nb_exp * BB);
    end
    chk("write_count", wq.size(), len);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      idx_exp = mode ? i % (NCU * NK) : i % NCU;
      if (wq[i].kb != mode || wq[i].idx != idx_exp ||
          wq[i].bits != 1 || i >= sent.size() ||
          wq[i].d !== sent[i]) bad++;
    end
    chk("write_order", bad, 0);
  endtask

  initial begin : main
    int t;
    int n0;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_ctrl",
        {load_busy, load_done, rstart, s_axis_tready}, 4'b0);
    chk("rst_raddr", raddr, 0);
    chk("rst_rnburst", rnburst, 0);
    chk("rst_we", 64'(wb_we != '0 || kb_we != '0), 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    gaps = 1'b0;
    run_load(1'b0, 32'h1000, 16, 1'b0, 1'b0);
    run_load(1'b1, 32'h2000, 32, 1'b0, 1'b0);
    run_load(1'b0, 32'h3000, 80, 1'b0, 1'b0);
    run_load(1'b0, 32'h4000, 20, 1'b0, 1'b0);
    run_load(1'b0, 32'h5000, 0, 1'b0, 1'b0);
    gaps = 1'b1;
    run_load(1'b1, 32'h6000, 100, 1'b1, 1'b0);
    run_load(1'b1, 32'h7000, 16, 1'b0, 1'b1);
    run_load(1'b1, 32'h7800, 200, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_load(1'($urandom), $urandom & 32'hffff_ff80,
               $urandom_range(1, 300), 1'b0, 1'b0);
    end

    // Reset in the middle of a streaming load
    wq.delete();
    @(posedge aclk);
    #1;
    load_start = 1'b1;
    load_mode  = 1'b0;
    load_addr  = 32'h9000;
    load_len   = BL'(40);
    @(posedge aclk);
    #1;
    load_start = 1'b0;
    t = 0;
    while (wq.size() < 5 && t < 500) begin
      @(negedge aclk);
      t++;
    end
    chk("mid_timeout", 64'(t < 500), 64'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("mid_rst_ctrl",
        {load_busy, load_done, rstart, s_axis_tready}, 4'b0);
    chk("mid_rst_addr", {raddr, rnburst}, 64'd0);
    chk("mid_rst_di", buf_di, 0);
    chk("mid_rst_we", 64'(wb_we != '0 || kb_we != '0), 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    n0 = wq.size();
    repeat (10) @(negedge aclk);
    chk("post_rst_quiet", wq.size(), n0);
    chk("post_rst_busy", load_busy, 1'b0);

    run_load(1'b0, 32'h8000, 18, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cu_buffer_loader.md
Name: cu_buffer_loader

Overview:
- Sits between the AXI read master's AXIS output and the conv_unit array.
- On a load command: requests a burst read of DDR, accepts the returned 64-bit beats, and scatters each beat into one conv unit's weight buffer or one kernel slot. Scatter is round-robin, selected by load_mode.
- Replaces the ad-hoc cu_sel counters and load FSM in the TPU top level.

Parameters:
- DATA_WIDTH, 64, AXIS/buffer word width.
- N_CONV_UNIT, 64, number of conv units fed.
- N_KERNEL, 3, kernel buffers per conv unit.
- BURST_BEATS, 16, beats per AXI burst (BURST_LENGTH+1).
- B_LEN, 24, width of the beat-count field.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- load_start  in  1  one-cycle command strobe
- load_mode  in  1  0 = weight buffers, 1 = kernel buffers; sampled with load_start
- load_addr  in  32  DDR byte address, 128-byte aligned; sampled with load_start
- load_len  in  B_LEN  number of 64-bit beats to deliver; sampled with load_start
- load_busy  out  1  high from accepted start until done
- load_done  out  1  one-cycle pulse at end of load
- rstart  out  1  read start to axi_mst (RSTART_REG)
- raddr  out  32  read address (RADDR_REG)
- rnburst  out  32  burst count (RNBURST_REG)
- ridle  in  1  axi_mst read idle (RIDLE_REG)
- s_axis_tdata  in  DATA_WIDTH  read data beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat ready
- buf_di  out  DATA_WIDTH  registered write data to all buffers
- wb_we  out  N_CONV_UNIT  one-hot weight-buffer write enable
- kb_we  out  N_CONV_UNIT*N_KERNEL  one-hot kernel write enable; bit index = cu*N_KERNEL + k

Behaviour:
- Reset values: all outputs 0. Internal state is IDLE; cu_sel, k_sel and beat counters are 0.
- FSM states: IDLE, REQ, STREAM, DRAIN, DONE.
- IDLE:
  - load_start=1 and load_len>0: latch mode/addr/len, set rnburst = ceil(len/BURST_BEATS), go to REQ.
  - load_start=1 and load_len=0: go to DONE; no read issued.
  - load_busy=0 only in IDLE.
- REQ:
  - rstart=1; raddr and rnburst held stable.
  - Stay in REQ until ridle=0, then rstart=0 and go to STREAM.
  - If ridle is already 0 when REQ is entered, stay in REQ; the read is issued only after ridle returns to 1.
- STREAM:
  - s_axis_tready=1; a beat is accepted when tvalid&tready.
  - Each accepted beat increments beat_cnt.
  - One cycle after acceptance: buf_di = tdata and exactly one enable bit is high for one cycle (latency 1).
  - Mode 0: wb_we[cu_sel]. cu_sel then increments, wrapping N_CONV_UNIT-1 -> 0.
  - Mode 1: kb_we[cu_sel*N_KERNEL+k_sel]. k_sel increments; when k_sel wraps N_KERNEL-1 -> 0, cu_sel increments (with the same wrap).
  - When beat_cnt reaches len, go to DRAIN if rnburst*BURST_BEATS > len, else go to DONE.
- DRAIN:
  - tready=1; excess beats are accepted and discarded, with no enables.
  - Go to DONE after rnburst*BURST_BEATS total beats.
- DONE:
  - load_done=1 for one cycle, then IDLE.
  - cu_sel and k_sel reset to 0 at the next load start.
- tready=0 in IDLE, REQ and DONE; tvalid in those states is ignored (beats are not consumed).
- load_start while busy is ignored.
- rnburst width rule: zero-extended from B_LEN-log2(BURST_BEATS) bits.
- Reset mid-operation: FSM returns to IDLE and no further enables are issued. axi_mst shares aresetn, so no dangling read remains.
- tvalid gaps: counters hold, enables stay 0.

Decomposition:
- Shared package tpu_pkg holds:
  - FSM state encoding;
  - load_mode constants (MODE_WEIGHT=0, MODE_KERNEL=1);
  - BURST_BEATS;
  - a function for ceil-divide of len to burst count.
- One sub-module, cu_sel_counter: the cu_sel/k_sel nested wrap counter with an enable and a mode input.

Test Plan:
- Mode 0, addr 0x1000, len 16, tvalid continuous:
  - rstart until ridle falls, rnburst=1;
  - wb_we bits 0..15 one-hot on consecutive cycles, buf_di matches the beats;
  - load_done pulses once.
- Mode 1, len 32:
  - kb_we indices 0..31 in order, i.e. (cu,k) = (0,0),(0,1),(0,2),(1,0)…(10,1);
  - wb_we stays 0.
- Mode 0, len 80 with N_CONV_UNIT=64:
  - rnburst=5; wb_we wraps, so beat 64 hits unit 0 and beat 79 hits unit 15.
- len 20:
  - rnburst=2; 20 enables, 12 drained beats with no enables;
  - load_done arrives after beat 32.
- len 0: load_done one cycle after start; rstart never asserted.
- Random tvalid gaps plus a second load_start while busy:
  - order and count are unchanged and the second start is ignored;
  - aresetn low mid-STREAM: all outputs are 0 the next cycle.
